// File: rtl/lsu_data_mem_pkg.sv
// Shared types and constants for the load/store unit data memory.
// Holds the FSM state encoding, RV32I load/store size codes and the default RAM depth.
package lsu_pkg;

  localparam int LSU_DEPTH = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_data_mem_if.sv
// Core-to-data-memory request/response bundle.
// Handshake: the core raises req with the access fields and holds req until ready; the memory
// pulses ready for exactly one cycle with rdata/err valid; stall = req && !ready.
interface lsu_data_mem_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (output req, we, funct3, addr, wdata, input rdata, ready, stall, err);
  modport slave  (input req, we, funct3, addr, wdata, output rdata, ready, stall, err);
endinterface

// File: rtl/lsu_data_mem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are zero at time zero and are deliberately not touched by reset.
module dmem_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH] = '{default: '0};
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end else if (en) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lsu_data_mem.sv
// Load/store unit front end to a word RAM: latches one access, checks alignment and size code,
// builds byte enables / replicated store data, and sign- or zero-extends load results.
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  lsu_data_mem_if.slave       bus,
  output lsu_state_e          state_o
);

  localparam int AW = $clog2(DEPTH);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            bad_f3, misalign;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata, ram_rdata, load_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            addr_hi_unused;

  // Address bits above the RAM index only alias, so they are intentionally dropped.
  assign addr_hi_unused = ^bus.addr[31:AW+2];

  always_comb begin
    bad_f3   = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111) ||
               (bus.we && ((bus.funct3 == F3_BU) || (bus.funct3 == F3_HU)));
    misalign = (((bus.funct3 == F3_H) || (bus.funct3 == F3_HU)) && bus.addr[0]) ||
               ((bus.funct3 == F3_W) && (bus.addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          f3_d    = bus.funct3;
          addr_d  = bus.addr[AW+1:0];
          wdata_d = bus.wdata;
          err_d   = bad_f3 || misalign;
          if (bad_f3 || misalign) state_d = S_RESP;
          else if (bus.we)        state_d = S_WRITE;
          else                    state_d = S_READ;
        end
      end
      S_READ:  state_d = S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = wdata_q;
    case (f3_q)
      F3_B: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // The RAM only sees activity in READ/WRITE, so a reset during WRITE cancels the store.
  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    ((state_q == S_READ) || (state_q == S_WRITE)),
    .we    (state_q == S_WRITE),
    .be    (ram_be),
    .addr  (addr_q[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    ld_byte  = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = ram_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val = ram_rdata;
    case (f3_q)
      F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_val = {24'h0, ld_byte};
      F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_val = {16'h0, ld_half};
      default: ;
    endcase
  end

  assign bus.ready = (state_q == S_RESP);
  assign bus.err   = (state_q == S_RESP) && err_q;
  assign bus.rdata = ((state_q == S_RESP) && !we_q && !err_q) ? load_val : 32'h0;
  assign bus.stall = bus.req && !bus.ready;
  assign state_o   = state_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench for lsu_data_mem: stores, loads of every size, error responses,
// address wrap, reset during a store and back-to-back loads with req held high.
module tb_lsu_data_mem;
  import lsu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  lsu_state_e state_o;
  int         passed = 0;
  int         total = 0;

  lsu_data_mem_if bus ();

  lsu_data_mem #(.DEPTH(256)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req    = 1'b1;
    bus.we     = wr;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = wd;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ex_rd, input logic ex_err, input int ex_lat);
    int   lat = 0;
    logic seen = 1'b0;
    logic stall_ok = 1'b1;
    drive(wr, f3, a, wd);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, ex_lat);
    check({tag, "_rdata"}, bus.rdata, ex_rd);
    check({tag, "_err"}, 32'(bus.err), 32'(ex_err));
    check({tag, "_stall_wait"}, 32'(stall_ok), 32'd1);
    bus.req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, 32'(bus.ready), 32'd0);
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = F3_W; bus.addr = '0; bus.wdata = '0;
    #12;
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    check("rst_rdata", bus.rdata,      32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    access("sw_10",  1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    access("lw_10",  1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    access("sb_13",  1'b1, F3_B,  32'h13, 32'h00000080, 32'h0,        1'b0, 2);
    access("lb_13",  1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2);
    access("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0,        32'h00000080, 1'b0, 2);
    access("lw_10b", 1'b0, F3_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 2);
    access("lh_11",  1'b0, F3_H,  32'h11, 32'h0,        32'h0,        1'b1, 1);
    access("lw_10c", 1'b0, F3_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 2);
    access("lh_12",  1'b0, F3_H,  32'h12, 32'h0,        32'hFFFF80AD, 1'b0, 2);
    access("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0,        32'h000080AD, 1'b0, 2);
    access("lb_11",  1'b0, F3_B,  32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 2);
    access("sbu_10", 1'b1, F3_BU, 32'h10, 32'h11111111, 32'h0,        1'b1, 1);
    access("ld_f3_3",1'b0, 3'b011,32'h10, 32'h0,        32'h0,        1'b1, 1);
    access("sw_12",  1'b1, F3_W,  32'h12, 32'h22222222, 32'h0,        1'b1, 1);
    access("lw_10d", 1'b0, F3_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 2);
    access("sw_400", 1'b1, F3_W,  32'h400,32'h12345678, 32'h0,        1'b0, 2);
    access("lw_000", 1'b0, F3_W,  32'h0,  32'h0,        32'h12345678, 1'b0, 2);
    access("sh_06",  1'b1, F3_H,  32'h6,  32'hABCD9876, 32'h0,        1'b0, 2);
    access("lw_04",  1'b0, F3_W,  32'h4,  32'h0,        32'h98760000, 1'b0, 2);
    access("lh_06",  1'b0, F3_H,  32'h6,  32'h0,        32'hFFFF9876, 1'b0, 2);

    // Request dropped and fields scrambled right after acceptance.
    drive(1'b1, F3_W, 32'h40, 32'hCAFEF00D);
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h44; bus.wdata = 32'h0BAD0BAD;
    check("drop_state", 32'(state_o), 32'(S_WRITE));
    @(posedge clk); #1;
    check("drop_ready", 32'(bus.ready), 32'd1);
    check("drop_err",   32'(bus.err),   32'd0);
    @(posedge clk); #1;
    access("lw_40", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    access("lw_44", 1'b0, F3_W, 32'h44, 32'h0, 32'h00000000, 1'b0, 2);

    // Reset in the middle of a store cancels it.
    drive(1'b1, F3_W, 32'h20, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check("rstw_state_write", 32'(state_o), 32'(S_WRITE));
    bus.req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rstw_state", 32'(state_o), 32'(S_IDLE));
    check("rstw_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    access("lw_20", 1'b0, F3_W, 32'h20, 32'h0, 32'h00000000, 1'b0, 2);

    // Three loads with req held high throughout.
    begin
      logic [31:0] b2b_addr [3];
      logic [31:0] b2b_exp  [3];
      int          pulses = 0;
      logic        stall_ok = 1'b1;
      b2b_addr[0] = 32'h10; b2b_exp[0] = 32'h80ADBEEF;
      b2b_addr[1] = 32'h00; b2b_exp[1] = 32'h12345678;
      b2b_addr[2] = 32'h04; b2b_exp[2] = 32'h98760000;
      for (int k = 0; k < 3; k++) begin
        logic seen = 1'b0;
        drive(1'b0, F3_W, b2b_addr[k], 32'h0);
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          if (bus.ready === 1'b1) begin
            seen = 1'b1;
            break;
          end
          if (bus.stall !== 1'b1) stall_ok = 1'b0;
        end
        if (seen) pulses++;
        check($sformatf("b2b_rdata_%0d", k), bus.rdata, b2b_exp[k]);
        check($sformatf("b2b_stall_ready_%0d", k), 32'(bus.stall), 32'd0);
      end
      bus.req = 1'b0;
      check("b2b_pulses", pulses, 32'd3);
      check("b2b_stall_wait", 32'(stall_ok), 32'd1);
      @(posedge clk); #1;
      check("b2b_idle_ready", 32'(bus.ready), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
